// File: rtl/ksa_pkg.sv
// ksa_pkg: shared definitions for the pipelined Kogge-Stone adder.
//   MAX_W      - widest operand the stage record can carry
//   clog2()    - ceiling log2, used to derive the number of prefix levels
//   width_ok() - legality check for the WIDTH parameter
//   stage_t    - one pipeline stage record {valid, g, p, x, amsb, bmsb, cin}
package ksa_pkg;

  localparam int MAX_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Legal widths are powers of two from 4 up to MAX_W.
  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= MAX_W) && ((w & (w - 1)) == 0);
  endfunction

  // Record carried between prefix levels. g/p/x are sized for MAX_W; bits at
  // and above the instance WIDTH are held at constant zero and prune away.
  typedef struct packed {
    logic             valid;
    logic [MAX_W-1:0] g;
    logic [MAX_W-1:0] p;
    logic [MAX_W-1:0] x;
    logic             amsb;
    logic             bmsb;
    logic             cin;
  } stage_t;

endpackage

// File: rtl/ksa_gp_cell.sv
// gp_cell: Kogge-Stone prefix operator (purely combinational).
//   Gi, Pi   - generate/propagate of the upper (bit i) group
//   Gj, Pj   - generate/propagate of the lower (bit i - span) group
//   Gij, Pij - combined group generate/propagate
module gp_cell (
  input  logic Gi,
  input  logic Pi,
  input  logic Gj,
  input  logic Pj,
  output logic Gij,
  output logic Pij
);

  assign Gij = Gi | (Pi & Gj);
  assign Pij = Pi & Pj;

endmodule

// File: rtl/ksa_pipe.sv
// ksa_pipe: fully pipelined Kogge-Stone adder/subtractor, LEVELS+2 cycles.
//   CLK, RST             - clock, asynchronous active-high reset
//   IN_VALID/IN_READY    - operand beat handshake (A, B, CI, SUB)
//   OUT_VALID/OUT_READY  - result beat handshake (S, CO, OVF, ZERO)
//   SUB=0: S = A+B+CI; SUB=1: S = A-B (CI ignored, CO=1 means no borrow)
//
// Handshake: a beat transfers on a rising CLK edge where valid && ready are
// both 1. A stalled result (OUT_VALID && !OUT_READY) freezes the whole
// pipeline and holds its outputs; IN_READY is simply the inverse of that
// stall, so a new beat is taken in the same cycle a result drains. Bubbles
// move through the pipe like beats and are never squeezed out.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO
);

  localparam int LEVELS = clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("ksa_pipe: WIDTH must be a power of two from 4 to 64");
  end

  logic stall;
  assign stall    = OUT_VALID && !OUT_READY;
  assign IN_READY = !stall;

  // Stage 0 inputs: subtraction is A + ~B + 1.
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;

  assign bx  = SUB ? ~B : B;
  assign cin = SUB ? 1'b1 : CI;
  assign p0  = A ^ bx;
  // Folding cin into bit 0 makes every later G[i] the true carry out of bit i.
  assign g0  = (A & bx) | {{(WIDTH-1){1'b0}}, p0[0] & cin};

  stage_t stg [LEVELS+1];

  logic [LEVELS:1][MAX_W-1:0] gn;
  logic [LEVELS:1][MAX_W-1:0] pn;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << (k - 1);
    for (genvar i = 0; i < MAX_W; i++) begin : g_bit
      if (i >= SPAN && i < WIDTH) begin : g_op
        gp_cell u_cell (
          .Gi  (stg[k-1].g[i]),
          .Pi  (stg[k-1].p[i]),
          .Gj  (stg[k-1].g[i-SPAN]),
          .Pj  (stg[k-1].p[i-SPAN]),
          .Gij (gn[k][i]),
          .Pij (pn[k][i])
        );
      end else begin : g_pass
        assign gn[k][i] = stg[k-1].g[i];
        assign pn[k][i] = stg[k-1].p[i];
      end
    end
  end

  // Final stage: after LEVELS levels, G[i] is the carry out of bit i.
  logic [WIDTH-1:0] c_f;
  logic [WIDTH-1:0] x_f;
  logic [WIDTH-1:0] s_f;

  assign c_f = stg[LEVELS].g[WIDTH-1:0];
  assign x_f = stg[LEVELS].x[WIDTH-1:0];
  assign s_f = x_f ^ {c_f[WIDTH-2:0], stg[LEVELS].cin};

  // Last-level propagate and the zero-padded upper bits are not needed.
  logic unused;
  assign unused = ^{stg[LEVELS].p, stg[LEVELS].g, stg[LEVELS].x};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k <= LEVELS; k++) stg[k] <= '0;
      OUT_VALID <= 1'b0;
      S         <= '0;
      CO        <= 1'b0;
      OVF       <= 1'b0;
      ZERO      <= 1'b0;
    end else if (!stall) begin
      stg[0] <= '{valid: IN_VALID,
                  g:     MAX_W'(g0),
                  p:     MAX_W'(p0),
                  x:     MAX_W'(p0),
                  amsb:  A[WIDTH-1],
                  bmsb:  bx[WIDTH-1],
                  cin:   cin};
      for (int k = 1; k <= LEVELS; k++) begin
        stg[k] <= '{valid: stg[k-1].valid,
                    g:     gn[k],
                    p:     pn[k],
                    x:     stg[k-1].x,
                    amsb:  stg[k-1].amsb,
                    bmsb:  stg[k-1].bmsb,
                    cin:   stg[k-1].cin};
      end
      OUT_VALID <= stg[LEVELS].valid;
      S         <= s_f;
      CO        <= c_f[WIDTH-1];
      OVF       <= (stg[LEVELS].amsb == stg[LEVELS].bmsb) &&
                   (s_f[WIDTH-1] != stg[LEVELS].amsb);
      ZERO      <= (s_f == '0);
    end
  end

endmodule

// File: tb/tb_ksa_pipe.sv
// tb_ksa_pipe: self-checking bench for ksa_pipe at WIDTH 8, 16 and 32.
// Directed scenarios run on the 16-bit instance; the random scenario checks
// all three instances against an integer-arithmetic reference model.
module tb_ksa_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        ci        = 1'b0;
  logic        sub       = 1'b0;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;

  logic [2:0]  rdy, ov, cov, ovfv, zv;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [31:0] sv [3];

  assign sv[0] = 32'(s8);
  assign sv[1] = 32'(s16);
  assign sv[2] = s32;

  int widths [3] = '{8, 16, 32};

  ksa_pipe #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy[0]),
    .A(a[7:0]), .B(b[7:0]), .CI(ci), .SUB(sub),
    .OUT_VALID(ov[0]), .OUT_READY(out_ready),
    .S(s8), .CO(cov[0]), .OVF(ovfv[0]), .ZERO(zv[0])
  );

  ksa_pipe #(.WIDTH(16)) u16 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy[1]),
    .A(a[15:0]), .B(b[15:0]), .CI(ci), .SUB(sub),
    .OUT_VALID(ov[1]), .OUT_READY(out_ready),
    .S(s16), .CO(cov[1]), .OVF(ovfv[1]), .ZERO(zv[1])
  );

  ksa_pipe #(.WIDTH(32)) u32 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy[2]),
    .A(a), .B(b), .CI(ci), .SUB(sub),
    .OUT_VALID(ov[2]), .OUT_READY(out_ready),
    .S(s32), .CO(cov[2]), .OVF(ovfv[2]), .ZERO(zv[2])
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // Result record: {zero, ovf, co, s}
  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];
  logic [34:0] exp_q2[$];

  function automatic void push_exp(input int d, input logic [34:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int exp_size(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [34:0] pop_exp(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic logic [34:0] got_rec(input int d);
    return {zv[d], ovfv[d], cov[d], sv[d]};
  endfunction

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic logic [34:0] model(input int w, input logic [31:0] ai,
                                        input logic [31:0] bi, input logic c_in,
                                        input logic sb_in);
    longint unsigned m, av, bv, sum;
    longint          sa, sb, r, hi, lo;
    logic            co, ovf;
    m  = (64'd1 << w) - 64'd1;
    av = 64'(ai) & m;
    bv = 64'(bi) & m;
    if (sb_in) begin
      sum = (av - bv) & m;
      co  = (av >= bv);
    end else begin
      sum = av + bv + 64'(c_in);
      co  = ((sum >> w) & 64'd1) != 0;
      sum = sum & m;
    end
    sa = $signed(av);
    sb = $signed(bv);
    if (((av >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
    if (((bv >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
    r  = sb_in ? (sa - sb) : (sa + sb + longint'(c_in));
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ovf = (r > hi) || (r < lo);
    return {sum == 0, ovf, co, 32'(sum)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (rdy[1] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", rdy[1]); end
    n_cmp++; if (ov[1] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ov[1]); end
    n_cmp++; if ({zv[1], ovfv[1], cov[1], s16} !== 19'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {zv[1], ovfv[1], cov[1], s16});
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_latency();
    int lat;
    logic [34:0] got;
    lat = 0;
    a = 32'hFFFF; b = 32'h0001; ci = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ov[1]) begin lat = c; break; end
    end
    got = got_rec(1);
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL latency: got %0d want 6", lat); end
    n_cmp++; if (got !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      n_bad++; $display("FAIL wrap_ffff_plus_1: got %h want %h", got, {1'b1, 1'b0, 1'b1, 32'h0});
    end
  endtask

  task automatic test_arith();
    logic [31:0] ta [5] = '{32'h7FFF, 32'h1234, 32'h0005, 32'h8000, 32'h1234};
    logic [31:0] tb [5] = '{32'h0001, 32'h0000, 32'h0007, 32'h0001, 32'h1234};
    logic        tc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [34:0] te [5] = '{{1'b0, 1'b1, 1'b0, 32'h8000},
                            {1'b0, 1'b0, 1'b0, 32'h1235},
                            {1'b0, 1'b0, 1'b0, 32'hFFFE},
                            {1'b0, 1'b1, 1'b1, 32'h7FFF},
                            {1'b1, 1'b0, 1'b1, 32'h0000}};
    int sent, recv;
    sent = 0; recv = 0; out_ready = 1'b1;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      @(negedge clk);
      in_valid = (sent < 5);
      if (sent < 5) begin a = ta[sent]; b = tb[sent]; ci = tc[sent]; sub = ts[sent]; end
      #1;
      if (ov[1] && out_ready) begin
        n_cmp++; if (got_rec(1) !== te[recv]) begin
          n_bad++; $display("FAIL arith_%0d: got %h want %h", recv, got_rec(1), te[recv]);
        end
        recv++;
      end
      if (in_valid && rdy[1]) sent++;
    end
    in_valid = 1'b0;
    n_cmp++; if (recv != 5) begin n_bad++; $display("FAIL arith_count: got %0d want 5", recv); end
  endtask

  task automatic test_back_to_back();
    int sent, recv;
    logic [34:0] held, got;
    logic exp_rdy;
    sent = 0; recv = 0; held = '0;
    exp_q1.delete();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 7 && c <= 9);
      in_valid  = (sent < 8);
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      if (c <= 14) begin
        exp_rdy = !(c >= 7 && c <= 9);
        n_cmp++; if (rdy[1] !== exp_rdy) begin
          n_bad++; $display("FAIL b2b_in_ready_c%0d: got %b want %b", c, rdy[1], exp_rdy);
        end
      end
      if (c == 7) held = got_rec(1);
      if (c >= 7 && c <= 9) begin
        got = got_rec(1);
        n_cmp++; if (ov[1] !== 1'b1 || got !== held) begin
          n_bad++; $display("FAIL b2b_hold_c%0d: got %b/%h want 1/%h", c, ov[1], got, held);
        end
      end
      if (ov[1] && out_ready) begin
        got = got_rec(1);
        if (exp_q1.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_extra: got %h want none", got);
        end else begin
          held = pop_exp(1);
          n_cmp++; if (got !== held) begin n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", recv, got, held); end
        end
        recv++;
      end
      if (in_valid && rdy[1]) begin
        push_exp(1, model(16, a, b, ci, sub));
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (recv != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", recv); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    logic [34:0] exp, got;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (ov[1] !== 1'b0 || rdy[1] !== 1'b1) begin
      n_bad++; $display("FAIL midrst_handshake: got ov=%b rdy=%b want ov=0 rdy=1", ov[1], rdy[1]);
    end
    n_cmp++; if ({zv[1], ovfv[1], cov[1], s16} !== 19'd0) begin
      n_bad++; $display("FAIL midrst_async_clear: got %h want 0", {zv[1], ovfv[1], cov[1], s16});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = $urandom; b = $urandom; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
    exp = model(16, a, b, ci, sub);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ov[1]) begin lat = c; break; end
    end
    got = got_rec(1);
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL midrst_latency: got %0d want 6", lat); end
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL midrst_result: got %h want %h", got, exp); end
  endtask

  task automatic test_random();
    int sent [3];
    int recv [3];
    bit feed, busy;
    logic [34:0] got, exp;
    rst = 1'b1; in_valid = 1'b0;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    for (int d = 0; d < 3; d++) begin sent[d] = 0; recv[d] = 0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      feed = (sent[0] < 2000) || (sent[1] < 2000) || (sent[2] < 2000);
      busy = (exp_size(0) + exp_size(1) + exp_size(2)) != 0;
      if (!feed && !busy) break;
      in_valid  = feed && ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          got = got_rec(d);
          if (exp_size(d) == 0) begin
            n_cmp++; n_bad++; $display("FAIL rand_w%0d_extra: got %h want none", widths[d], got);
          end else begin
            exp = pop_exp(d);
            n_cmp++; if (got !== exp) begin
              n_bad++; $display("FAIL rand_w%0d_beat%0d: got %h want %h", widths[d], recv[d], got, exp);
            end
          end
          recv[d]++;
        end
        if (in_valid && rdy[d]) begin
          push_exp(d, model(widths[d], a, b, ci, sub));
          sent[d]++;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++; if (recv[d] != sent[d] || sent[d] < 2000) begin
        n_bad++; $display("FAIL rand_w%0d_count: got %0d results want %0d (sent %0d)", widths[d], recv[d], sent[d], sent[d]);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ksa_pipe.md
KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are powers of two from 4 to 64.
REQ-002 SHALL have derived localparam LEVELS = log2(WIDTH), the number of prefix levels.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: ports CLK and RST.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 IN_VALID  input  1  operand beat present.
REQ-007 IN_READY  output  1  block accepts beat this cycle.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 CI  input  1  carry-in; used in add mode only.
REQ-011 SUB  input  1  0 = A+B+CI; 1 = A-B.
REQ-012 OUT_VALID  output  1  result beat present.
REQ-013 OUT_READY  input  1  downstream accepts result.
REQ-014 S  output  WIDTH  sum or difference.
REQ-015 CO  output  1  carry-out; in subtract mode, 1 = no borrow.
REQ-016 OVF  output  1  two's-complement signed overflow.
REQ-017 ZERO  output  1  S == 0.

Function
REQ-018 Input transfer SHALL occur when IN_VALID && IN_READY.
REQ-019 Output transfer SHALL occur when OUT_VALID && OUT_READY.
REQ-020 SUB=1 SHALL compute on B' = ~B with effective carry-in 1, ignoring CI; SUB=0 SHALL use B' = B and carry-in CI.
REQ-021 Stage 0 SHALL compute g = A&B' and p = A^B', fold carry-in into bit 0 (g0 = g0 | p0&cin), and register g, p, A^B', A[MSB], B'[MSB] and a valid bit.
REQ-022 Stages 1..LEVELS SHALL each apply one Kogge-Stone level with span 2^(k-1): (G,P)[i] = (Gi | Pi&Gj, Pi&Pj) for j = i-2^(k-1) >= 0, and pass through bits with j < 0; each stage is registered.
REQ-023 The final stage SHALL register the following, with c[-1] = cin: S[i] = x[i]^c[i-1], CO = c[WIDTH-1], OVF = (A[MSB]==B'[MSB]) && (S[MSB]!=A[MSB]), ZERO.
REQ-024 Latency SHALL be LEVELS+2 cycles from input transfer to OUT_VALID with no stall (6 cycles at WIDTH=16).
REQ-025 Throughput SHALL be one beat per cycle when OUT_READY=1.
REQ-026 Stall rule: stall = OUT_VALID && !OUT_READY; while stalled, all pipeline registers hold and IN_READY=0.
REQ-027 IN_READY SHALL equal !stall, combinationally.
REQ-028 Bubbles SHALL advance normally when not stalled; bubbles are not collapsed.
REQ-029 Results SHALL leave in acceptance order, with no loss or duplication under any OUT_READY pattern.
REQ-030 S, CO, OVF and ZERO SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-031 Arithmetic SHALL be modulo 2^WIDTH; CO carries the 2^WIDTH bit.
REQ-032 An input arriving in the same cycle as an output transfer at full occupancy SHALL be accepted.

Reset
REQ-033 RST=1 SHALL clear all valid bits and clear S, CO, OVF and ZERO to 0 immediately, without waiting for CLK.
REQ-034 While RST=1, IN_READY=1 and OUT_VALID=0; no transfer is counted.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight beats; the first output after release comes from a beat accepted after release.

Structure
REQ-036 Shared package ksa_pkg SHALL hold the clog2 function, the WIDTH legality check, and a stage-record typedef {valid, g, p, x, amsb, bmsb, cin}.
REQ-037 The single sub-module SHALL be gp_cell: combinational prefix operator with inputs Gi, Pi, Gj, Pj and outputs Gij, Pij.
REQ-038 Levels SHALL be built with generate loops; no hand-unrolled instances.

Verification (WIDTH=16 unless stated)
REQ-039 Add 0xFFFF+0x0001, CI=0 -> S=0x0000, CO=1, ZERO=1, OVF=0, exactly 6 cycles after accept.
REQ-040 Add 0x7FFF+0x0001, CI=0 -> S=0x8000, CO=0, OVF=1; add 0x1234+0x0000, CI=1 -> S=0x1235.
REQ-041 SUB 0x0005-0x0007 (CI=1, ignored) -> S=0xFFFE, CO=0, OVF=0; SUB 0x8000-0x0001 -> S=0x7FFF, CO=1, OVF=1.
REQ-042 Back-to-back backpressure: 8 consecutive beats, OUT_READY low for cycles 7-9 -> IN_READY low for those cycles, all 8 results in order, each stalled output held stable.
REQ-043 Reset mid-flight: RST pulse after 3 beats accepted -> OUT_VALID=0 at once, none of the 3 ever emitted, next beat returns in 6 cycles.
REQ-044 Random: 2000 beats with random OUT_READY, WIDTH in {8,16,32} -> S, CO and OVF match the behavioural model, in order.
